// File: rtl/axi_burst_master.sv
// axi_burst_master
// Single-outstanding AXI4 INCR burst initiator. A simple request port starts
// one read (AR/R) or write (AW/W/B) transaction at a time. Read and write beats
// pass combinationally between the local streams and the AXI R/W channels.
// rsp_valid pulses once per transaction. rsp_err reports any bad response,
// ID mismatch or misplaced rlast seen during that transaction.
//
// Ports
//   clk_axi_in, rst                       clock, async active-high reset
//   req_*                                 request handshake + burst fields
//   wr_valid/wr_ready/wr_data/wr_strb     write-beat stream (into the master)
//   rd_valid/rd_ready/rd_data/rd_last     read-beat stream (out of the master)
//   rsp_valid/rsp_err                     completion pulse + status
//   axi_ar*/axi_r*/axi_aw*/axi_w*/axi_b*  AXI4 initiator channels
module axi_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  localparam int STRB      = DATA_WIDTH / 8
) (
  input  logic                  clk_axi_in,
  input  logic                  rst,
  // request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  // write-data stream
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB-1:0]       wr_strb,
  // read-data stream
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  // completion
  output logic                  rsp_valid,
  output logic                  rsp_err,
  // AR channel
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  // R channel
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  // AW channel
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  // W channel
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [STRB-1:0]       axi_wstrb,
  output logic                  axi_wlast,
  // B channel
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  input  logic [ID_WIDTH-1:0]   axi_bid
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RSP} state_t;

  localparam logic [ID_WIDTH-1:0] ID_C       = ID_WIDTH'(AXI_ID);
  localparam logic [1:0]          BURST_INCR = 2'b01;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [7:0]              beat_q;
  logic                    err_q;

  logic last_beat;
  logic r_hs;
  logic w_hs;

  assign last_beat = (beat_q == len_q);
  assign r_hs      = (state_q == R) && axi_rvalid && rd_ready;
  assign w_hs      = (state_q == W) && wr_valid && axi_wready;

  // Address channels are driven straight from the latched request, so they
  // stay stable for as long as the slave stalls the handshake.
  assign axi_araddr  = addr_q;
  assign axi_arid    = ID_C;
  assign axi_arlen   = len_q;
  assign axi_arsize  = size_q;
  assign axi_arburst = BURST_INCR;
  assign axi_awaddr  = addr_q;
  assign axi_awid    = ID_C;
  assign axi_awlen   = len_q;
  assign axi_awsize  = size_q;
  assign axi_awburst = BURST_INCR;

  // Payloads are plain pass-through; only the qualifiers depend on state.
  assign rd_data   = axi_rdata;
  assign axi_wdata = wr_data;
  assign axi_wstrb = wr_strb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_axi_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal this block drives gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_rready  = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    axi_wvalid  = 1'b0;
    wr_ready    = 1'b0;
    axi_wlast   = 1'b0;
    axi_bready  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_write ? AW : AR;
      end
      AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_d = R;
      end
      R: begin
        rd_valid   = axi_rvalid;
        axi_rready = rd_ready;
        rd_last    = last_beat;
        // Termination follows the local beat count, never the slave's rlast.
        if (r_hs && last_beat) state_d = RSP;
      end
      AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_d = W;
      end
      W: begin
        axi_wvalid = wr_valid;
        wr_ready   = axi_wready;
        axi_wlast  = last_beat;
        if (w_hs && last_beat) state_d = B;
      end
      B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_axi_in or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        size_q <= req_size;
        beat_q <= '0;
        err_q  <= 1'b0;
      end
      // The counter holds at the final beat, so len 255 never wraps to 0.
      if ((r_hs || w_hs) && !last_beat) beat_q <= beat_q + 8'd1;
      if (r_hs && ((axi_rresp != 2'b00) || (axi_rid != ID_C) || (axi_rlast != last_beat)))
        err_q <= 1'b1;
      if (state_q == B && axi_bvalid && ((axi_bresp != 2'b00) || (axi_bid != ID_C)))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master. A table of transactions drives a
// behavioural AXI slave and local-stream agent. Expected beats and completion
// status are queued when each request is issued and popped as the DUT
// produces them. A hand-written sequence covers reset in the middle of a burst.
module tb_axi_burst_master;

  logic        clk_axi_in = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        rsp_valid, rsp_err;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready, axi_rlast;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic [3:0]  axi_rid;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [3:0]  axi_awid;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;

  axi_burst_master dut (
    .clk_axi_in(clk_axi_in), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_bid(axi_bid)
  );

  always #5 clk_axi_in = ~clk_axi_in;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          addr_delay;  // cycles arready/awready stays low
    bit          toggle;      // stall every other data cycle
    logic [1:0]  resp;        // rresp on every beat, or bresp
    int          bad_last;    // read beat that also carries rlast (-1: none)
    bit          bad_id;      // slave answers with the wrong ID
    logic [63:0] base;        // beat i carries base + i
    bit          exp_err;
  } txn_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  bit    err_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input int dly, input bit tog,
                              input logic [1:0] resp, input int bad_last, input bit bad_id,
                              input logic [63:0] base, input bit exp_err);
    txn_t t;
    t.wr = wr; t.addr = addr; t.len = len; t.size = size; t.addr_delay = dly;
    t.toggle = tog; t.resp = resp; t.bad_last = bad_last; t.bad_id = bad_id;
    t.base = base; t.exp_err = exp_err;
    return t;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_size = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    axi_arready = 0; axi_awready = 0;
    axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0; axi_rid = '0;
    axi_wready = 0; axi_bvalid = 0; axi_bresp = '0; axi_bid = '0;
  endtask

  task automatic do_txn(input txn_t t);
    int    sent;
    int    cyc;
    int    budget;
    int    nbeats;
    beat_t e;
    nbeats = int'(t.len) + 1;
    for (int i = 0; i < nbeats; i++)
      exp_q.push_back('{data: t.base + 64'(i), strb: 8'hF0 ^ 8'(i), last: (i == nbeats - 1)});
    err_q.push_back(t.exp_err);

    @(negedge clk_axi_in);
    req_valid = 1; req_write = t.wr; req_addr = t.addr; req_len = t.len; req_size = t.size;
    // Write data is offered early; it must not reach W before the AW handshake.
    wr_valid = t.wr; wr_data = t.base; wr_strb = 8'hF0;
    #1 check("req_ready_idle", req_ready, 1);

    for (int c = 0; c <= t.addr_delay; c++) begin
      @(negedge clk_axi_in);
      req_valid   = 0;
      axi_arready = !t.wr && (c == t.addr_delay);
      axi_awready = t.wr && (c == t.addr_delay);
      #1;
      check("req_ready_busy", req_ready, 0);
      if (t.wr) begin
        check("awvalid", axi_awvalid, 1);
        check("awaddr", axi_awaddr, t.addr);
        check("awlen", axi_awlen, t.len);
        check("awsize", axi_awsize, t.size);
        check("awburst", axi_awburst, 2'b01);
        check("awid", axi_awid, 4'd0);
        check("w_before_aw", axi_wvalid, 0);
        check("wr_ready_before_aw", wr_ready, 0);
      end else begin
        check("arvalid", axi_arvalid, 1);
        check("araddr", axi_araddr, t.addr);
        check("arlen", axi_arlen, t.len);
        check("arsize", axi_arsize, t.size);
        check("arburst", axi_arburst, 2'b01);
        check("arid", axi_arid, 4'd0);
        check("awvalid_on_read", axi_awvalid, 0);
      end
    end

    budget = 4 * nbeats + 20;
    sent   = 0;
    cyc    = 0;
    while (sent < nbeats && cyc < budget) begin
      @(negedge clk_axi_in);
      axi_arready = 0; axi_awready = 0;
      if (t.wr) begin
        wr_valid   = 1;
        wr_data    = t.base + 64'(sent);
        wr_strb    = 8'hF0 ^ 8'(sent);
        axi_wready = t.toggle ? (cyc % 2 == 1) : 1'b1;
        #1;
        e = exp_q[0];
        check("wvalid", axi_wvalid, 1);
        check("wdata", axi_wdata, e.data);
        check("wstrb", axi_wstrb, e.strb);
        check("wlast", axi_wlast, e.last);
        check("wr_ready", wr_ready, axi_wready);
        if (axi_wready) begin
          exp_q.delete(0);
          sent++;
        end
      end else begin
        axi_rvalid = 1;
        axi_rdata  = t.base + 64'(sent);
        axi_rresp  = t.resp;
        axi_rid    = t.bad_id ? 4'd1 : 4'd0;
        axi_rlast  = (sent == nbeats - 1) || (sent == t.bad_last);
        rd_ready   = t.toggle ? (cyc % 2 == 0) : 1'b1;
        #1;
        check("rready", axi_rready, rd_ready);
        if (rd_ready) begin
          e = exp_q[0];
          exp_q.delete(0);
          check("rd_valid", rd_valid, 1);
          check("rd_data", rd_data, e.data);
          check("rd_last", rd_last, e.last);
          sent++;
        end
      end
      cyc++;
    end
    check(t.wr ? "w_beats" : "r_beats", sent, nbeats);

    @(negedge clk_axi_in);
    wr_valid = 0; axi_wready = 0; axi_rvalid = 0; axi_rlast = 0; rd_ready = 0;
    axi_rresp = '0; axi_rid = '0;
    if (t.wr) begin
      #1;
      check("bready", axi_bready, 1);
      check("rsp_before_b", rsp_valid, 0);
      @(negedge clk_axi_in);
      axi_bvalid = 1; axi_bresp = t.resp; axi_bid = t.bad_id ? 4'd1 : 4'd0;
      @(negedge clk_axi_in);
      axi_bvalid = 0; axi_bresp = '0; axi_bid = '0;
    end
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, err_q.pop_front());
    check("req_ready_in_rsp", req_ready, 0);
    @(negedge clk_axi_in);
    #1;
    check("rsp_pulse_end", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  txn_t tbl[9];

  initial begin
    tbl[0] = mk(0, 32'h8000_0000, 8'd0,   3'd3, 0, 0, 2'b00, -1, 0, 64'h1122_3344_5566_7788, 0);
    tbl[1] = mk(0, 32'h0000_1000, 8'd3,   3'd3, 5, 1, 2'b00, -1, 0, 64'hA000_0000_0000_0000, 0);
    tbl[2] = mk(1, 32'h0000_2000, 8'd3,   3'd3, 0, 1, 2'b00, -1, 0, 64'hB000_0000_0000_0010, 0);
    tbl[3] = mk(1, 32'h0000_3000, 8'd0,   3'd3, 1, 0, 2'b10, -1, 0, 64'hC000_0000_0000_0000, 1);
    tbl[4] = mk(1, 32'h0000_3100, 8'd1,   3'd2, 0, 0, 2'b00, -1, 0, 64'hC100_0000_0000_0000, 0);
    tbl[5] = mk(0, 32'h0000_4000, 8'd3,   3'd3, 0, 0, 2'b00,  1, 0, 64'hD000_0000_0000_0000, 1);
    tbl[6] = mk(0, 32'h0000_5000, 8'd1,   3'd3, 2, 0, 2'b10, -1, 0, 64'hE000_0000_0000_0000, 1);
    tbl[7] = mk(1, 32'h0000_6000, 8'd2,   3'd3, 0, 0, 2'b00, -1, 1, 64'hF000_0000_0000_0000, 1);
    tbl[8] = mk(0, 32'h0000_7000, 8'd255, 3'd3, 1, 0, 2'b00, -1, 0, 64'h0123_0000_0000_0000, 0);

    idle_inputs();
    rst = 1;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wvalid", axi_wvalid, 0);
    check("rst_bready", axi_bready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_wlast", axi_wlast, 0);
    check("rst_araddr", axi_araddr, 0);
    check("rst_arlen", axi_arlen, 0);
    check("rst_arburst", axi_arburst, 2'b01);
    check("rst_awburst", axi_awburst, 2'b01);
    repeat (2) @(negedge clk_axi_in);
    rst = 0;

    foreach (tbl[i]) do_txn(tbl[i]);

    // Reset in the middle of beat 2 of a len-7 write.
    @(negedge clk_axi_in);
    req_valid = 1; req_write = 1; req_addr = 32'h0000_9000; req_len = 8'd7; req_size = 3'd3;
    @(negedge clk_axi_in);
    req_valid = 0; axi_awready = 1;
    #1 check("mid_rst_awvalid", axi_awvalid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_axi_in);
      axi_awready = 0; wr_valid = 1; wr_data = 64'hDEAD_0000 + 64'(i); wr_strb = 8'hFF;
      axi_wready = 1;
      #1 check("mid_rst_wvalid", axi_wvalid, 1);
    end
    rst = 1;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_awvalid_low", axi_awvalid, 0);
    check("mid_rst_wvalid_low", axi_wvalid, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_wlast", axi_wlast, 0);
    check("mid_rst_bready", axi_bready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_awaddr", axi_awaddr, 0);
    check("mid_rst_awlen", axi_awlen, 0);
    @(negedge clk_axi_in);
    idle_inputs();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_axi_in);
      #1;
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_req_ready", req_ready, 1);
    end
    do_txn(mk(0, 32'h8000_0040, 8'd0, 3'd3, 0, 0, 2'b00, -1, 0, 64'h5555_AAAA_5555_AAAA, 0));

    repeat (2) @(negedge clk_axi_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding AXI4 burst initiator that turns a simple request/stream interface into AR/R or AW/W/B transactions. It is the initiator counterpart of the `axi_slave_mem` responder. It lets bench drivers, DMA-style agents or a second core-side client drive any AXI4 slave, including the core's `io_slave` port or `axi_slave_mem`. Exactly one transaction is in flight at a time. Burst type is always INCR.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, AXI data width; STRB = DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width
- AXI_ID, 0, constant ID driven on `arid`/`awid` and expected on `rid`/`bid`

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid / req_ready  in/out  1/1  request handshake
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  start byte address
- req_len  in  8  beats minus 1 (AXI len)
- req_size  in  3  AXI size, must be ≤ log2(STRB)
- wr_valid / wr_ready  in/out  1/1  write-data stream handshake
- wr_data / wr_strb  in  DATA_WIDTH/STRB  write beat payload
- rd_valid / rd_ready  out/in  1/1  read-data stream handshake
- rd_data / rd_last  out  DATA_WIDTH/1  read beat payload; last beat flag
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  completion status; valid with `rsp_valid`
- axi_ar{valid,ready,addr,id,len,size,burst}  out/in/out…  1/1/ADDR_WIDTH/ID_WIDTH/8/3/2  AR channel
- axi_r{valid,ready,data,resp,last,id}  in/out/in…  1/1/DATA_WIDTH/2/1/ID_WIDTH  R channel
- axi_aw{valid,ready,addr,id,len,size,burst}  out/in/out…  1/1/ADDR_WIDTH/ID_WIDTH/8/3/2  AW channel
- axi_w{valid,ready,data,strb,last}  out/in/out…  1/1/DATA_WIDTH/STRB/1  W channel
- axi_b{valid,ready,resp,id}  in/out/in/in  1/1/2/ID_WIDTH  B channel

## Operation
- FSM states: IDLE, AR, R, AW, W, B, RSP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch addr/len/size/write, clear the beat counter and the sticky error.
  - Next state is AW if `req_write` = 1, else AR.
- **AR / AW**
  - Drive the registered `valid` with the latched fields; `burst` = 2'b01 and `id` = AXI_ID.
  - Hold all fields stable until `ready`.
  - AR then goes to R; AW then goes to W. W data is never sent before the AW handshake.
- **R**
  - Pass-through:
    - `rd_valid` = `axi_rvalid`
    - `axi_rready` = `rd_ready`
    - `rd_data` = `axi_rdata`
    - `rd_last` = (beat == len)
  - Each handshake increments the beat counter.
  - Set the sticky error on any of:
    - `rresp` ≠ 0
    - `rid` ≠ AXI_ID
    - `rlast` mismatching (beat == len)
  - After the handshake at beat == len, go to RSP. An early `rlast` does not terminate the burst.
- **W**
  - Pass-through:
    - `axi_wvalid` = `wr_valid`
    - `wr_ready` = `axi_wready`
    - `axi_wdata` = `wr_data`
    - `axi_wstrb` = `wr_strb`
    - `axi_wlast` = (beat == len)
  - Each handshake increments the beat counter; after the handshake at beat == len, go to B.
- **B**
  - `axi_bready` = 1.
  - On `bvalid`: set the sticky error if `bresp` ≠ 0 or `bid` ≠ AXI_ID, then go to RSP.
- **RSP**
  - `rsp_valid` = 1 for one cycle, `rsp_err` = sticky error, then go to IDLE.
- Outside their own state, all handshake outputs are 0 and `wr_ready`/`rd_valid` are 0.
- Beat counter is 8 bits and never wraps: maximum len 255 gives 256 beats.

## Timing
- Reset values:
  - all `valid`/`ready` outputs 0 except `req_ready` = 1
  - `rsp_valid` = 0, `rsp_err` = 0, `rd_last` = 0, `axi_wlast` = 0
  - addr/len/size/id outputs = 0; `burst` = 2'b01
- Request accepted at edge N: `axi_arvalid`/`axi_awvalid` is 1 from cycle N+1.
- R and W stages are zero-latency combinational pass-through; throughput is one beat per cycle.
- Final R or B handshake at edge M: `rsp_valid` is high during cycle M+1.
- `req_ready` returns to 1 in cycle M+2.
- Reset asserted mid-burst: the FSM goes to IDLE asynchronously and no `rsp_valid` is emitted. Valids are dropped without completing the handshake; the bench resets the slave as well.
- `req_valid` while not IDLE is ignored, since `req_ready` = 0.

## Test plan
- Read, addr 0x8000_0000, len 0, slave returns 0x1122334455667788 OKAY with `rlast`:
  - one `rd_valid` beat with `rd_last` = 1
  - `rsp_valid` pulse with `rsp_err` = 0
  - `arlen` = 0, `arburst` = 1
- Read, len 3, `rd_ready` toggling 1,0,1,0…:
  - exactly 4 beats in order
  - `rd_last` only on beat 3
  - `arvalid` held with stable fields while `arready` is delayed 5 cycles
- Write, len 3, `axi_wready` low every other cycle:
  - 4 W beats with data/strb unchanged
  - `wlast` only on beat 3
  - no `wvalid` before the AW handshake
  - `rsp_err` = 0
- Write returning `bresp` = 2'b10 (SLVERR): `rsp_err` = 1; the next request is accepted normally with `rsp_err` = 0.
- Read len 3 with the slave asserting `rlast` on beat 1: all 4 beats are still consumed and `rsp_err` = 1.
- Reset asserted during beat 2 of a len-7 write: all outputs reach reset values in the same cycle, then a new len-0 read completes cleanly.
